// File: rtl/inv_f_3.sv
// inv_f_3: inverse of forward stage 3. Lanes 0/1/4/5 are scaled by 1/sqrt(2) on one shared multiplier, and lanes (2,3),(6,7) get the inverse butterfly.
// Optional build macro INV_F_3_ROUND_EN selects round-half-up instead of truncation.
`default_nettype none

module inv_f_3 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [11:0] I0,
  input  logic [11:0] I1,
  input  logic [11:0] I2,
  input  logic [11:0] I3,
  input  logic [11:0] I4,
  input  logic [11:0] I5,
  input  logic [11:0] I6,
  input  logic [11:0] I7,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [11:0] O0,
  output logic [11:0] O1,
  output logic [11:0] O2,
  output logic [11:0] O3,
  output logic [11:0] O4,
  output logic [11:0] O5,
  output logic [11:0] O6,
  output logic [11:0] O7
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCALE = 2'd1;
  localparam logic [1:0] BFLY  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [25:0] K_Q15 = 26'd23170;
`ifdef INV_F_3_ROUND_EN
  localparam logic [25:0] RND_Q15  = 26'd16384;
  localparam logic [11:0] RND_HALF = 12'd1;
`else
  localparam logic [25:0] RND_Q15  = 26'd0;
  localparam logic [11:0] RND_HALF = 12'd0;
`endif

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [11:0] in_vec [8];
  logic [11:0] in_norm [8];
  logic [11:0] n [8];
  logic [11:0] o_q [8];

  assign in_vec[0] = I0;
  assign in_vec[1] = I1;
  assign in_vec[2] = I2;
  assign in_vec[3] = I3;
  assign in_vec[4] = I4;
  assign in_vec[5] = I5;
  assign in_vec[6] = I6;
  assign in_vec[7] = I7;

  // Negative zero is folded to +0 on capture so downstream logic never sees it.
  for (genvar g = 0; g < 8; g++) begin : g_norm
    assign in_norm[g] = (in_vec[g][10:0] == 11'd0) ? 12'd0 : in_vec[g];
  end

  assign IN_READY  = (state == IDLE) && !RESET;
  assign OUT_VALID = (state == HOLD);

  assign O0 = o_q[0];
  assign O1 = o_q[1];
  assign O2 = o_q[2];
  assign O3 = o_q[3];
  assign O4 = o_q[4];
  assign O5 = o_q[5];
  assign O6 = o_q[6];
  assign O7 = o_q[7];

  // Counter 0..3 maps to lanes 0,1,4,5.
  logic [2:0]  lane;
  logic [10:0] mul_mag;
  logic [10:0] scaled_mag;
  logic [11:0] scaled_word;

  assign lane        = {cnt[1], 1'b0, cnt[0]};
  assign mul_mag     = n[lane][10:0];
  assign scaled_mag  = 11'(((({15'd0, mul_mag} * K_Q15) + RND_Q15) >> 15));
  assign scaled_word = {n[lane][11] & (scaled_mag != 11'd0), scaled_mag};

  logic [12:0] tc [8];
  logic [12:0] bf_sum [2];
  logic [12:0] bf_dif [2];
  logic [11:0] bf_sum_w [2];
  logic [11:0] bf_dif_w [2];

  for (genvar g = 0; g < 8; g++) begin : g_tc
    assign tc[g] = n[g][11] ? (13'd0 - {2'b00, n[g][10:0]}) : {2'b00, n[g][10:0]};
  end

  // Sums lie within +/-4094, so the low 12 bits of the negation are the exact magnitude.
  for (genvar p = 0; p < 2; p++) begin : g_bfly
    logic [11:0] sum_abs;
    logic [11:0] dif_abs;
    logic [10:0] sum_mag;
    logic [10:0] dif_mag;

    assign bf_sum[p] = tc[4*p+2] + tc[4*p+3];
    assign bf_dif[p] = tc[4*p+2] - tc[4*p+3];
    assign sum_abs   = bf_sum[p][12] ? (~bf_sum[p][11:0] + 12'd1) : bf_sum[p][11:0];
    assign dif_abs   = bf_dif[p][12] ? (~bf_dif[p][11:0] + 12'd1) : bf_dif[p][11:0];
    assign sum_mag   = 11'((sum_abs + RND_HALF) >> 1);
    assign dif_mag   = 11'((dif_abs + RND_HALF) >> 1);
    assign bf_sum_w[p] = {bf_sum[p][12] & (sum_mag != 11'd0), sum_mag};
    assign bf_dif_w[p] = {bf_dif[p][12] & (dif_mag != 11'd0), dif_mag};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 2'd0;
      for (int i = 0; i < 8; i++) begin
        n[i]   <= 12'd0;
        o_q[i] <= 12'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            for (int i = 0; i < 8; i++) begin
              n[i] <= in_norm[i];
            end
            cnt   <= 2'd0;
            state <= SCALE;
          end
        end
        SCALE: begin
          o_q[lane] <= scaled_word;
          cnt       <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= BFLY;
          end
        end
        BFLY: begin
          o_q[2] <= bf_sum_w[0];
          o_q[3] <= bf_dif_w[0];
          o_q[6] <= bf_sum_w[1];
          o_q[7] <= bf_dif_w[1];
          state  <= HOLD;
        end
        HOLD: begin
          if (OUT_READY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
